// File: rtl/cordic_fp_pkg.sv
// Shared floating-point constants and control-state encoding for the CORDIC
// float pack/unpack stages.
package cordic_fp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } state_t;

  localparam int FP_BIAS   = 127;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;
  // Exponent arithmetic is one bit wider than the field.
  localparam int FP_EXPC_W = 9;

endpackage : cordic_fp_pkg

// File: rtl/packer.sv
// Iterative fixed-point to IEEE-754 single converter: normalises one bit per
// cycle, truncates the mantissa and returns the float over valid/ready.
module packer
  import cordic_fp_pkg::*;
#(
  parameter int FRACTIONAL_BITS = 30,
  parameter bit SIGNED          = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  localparam logic [FP_EXPC_W-1:0] EXP_BASE =
    FP_EXPC_W'(FP_BIAS + 31 - FRACTIONAL_BITS);

  state_t             state_q, state_d;
  logic [31:0]        mag_q, mag_d;
  logic [5:0]         lz_q, lz_d;
  logic               sign_q, sign_d;
  logic [31:0]        result_q, result_d;
  logic               sign_in;
  logic [FP_EXP_W-1:0] exp_field;

  assign sign_in   = SIGNED && data[31];
  assign exp_field = FP_EXP_W'(EXP_BASE - FP_EXPC_W'(lz_q));

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    lz_d     = lz_q;
    sign_d   = sign_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = sign_in;
          // NOTE: blocking assignments here; combinational logic is evaluated in order.
          mag_d   = sign_in ? (~data + 32'd1) : data;
          lz_d    = '0;
          state_d = NORM;
        end
      end
      NORM: begin
        if (mag_q == '0) begin
          // Zero is emitted unsigned: there is no negative zero.
          result_d = '0;
          state_d  = DONE;
        end else if (mag_q[31]) begin
          result_d = {sign_q, exp_field, mag_q[30:8]};
          state_d  = DONE;
        end else begin
          mag_d = mag_q << 1;
          lz_d  = lz_q + 6'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments for all registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mag_q    <= '0;
      lz_q     <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      lz_q     <= lz_d;
      sign_q   <= sign_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule : packer

// File: tb/tb_packer.sv
// Scoreboard bench for packer: a signed and an unsigned instance, a value-level
// reference model, directed corner cases, backpressure, mid-operation reset.
module tb_packer;

  localparam int FB = 30;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] data = '0;
  logic        out_ready = 1'b0;
  logic        sel = 1'b0;        // 0: signed instance, 1: unsigned instance
  logic        iv0, iv1, rdy0, rdy1, ov0, ov1;
  logic [31:0] res0, res1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rmode = 0;                // 0: ready high, 1: random, 2: manual
  int   last_acc = -1;
  int   xfer_cyc = -1;
  bit   seen = 1'b0;
  logic [31:0] held = '0;
  sb_t  sbq[$];

  assign iv0 = in_valid && !sel;
  assign iv1 = in_valid && sel;

  packer #(.FRACTIONAL_BITS(FB), .SIGNED(1'b1)) u_s (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(rdy0), .data(data),
    .out_valid(ov0), .out_ready(out_ready), .result(res0));

  packer #(.FRACTIONAL_BITS(FB), .SIGNED(1'b0)) u_u (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(rdy1), .data(data),
    .out_valid(ov1), .out_ready(out_ready), .result(res1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (rmode == 0) out_ready = 1'b1;
    else if (rmode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: real-valued magnitude, locate the leading one, scale to 1.m.
  function automatic void model(input logic [31:0] d, input bit sgn,
                                output logic [31:0] r, output int lat);
    logic        s;
    logic [31:0] m, norm;
    int          p, e;
    s = sgn && d[31];
    m = s ? 32'(33'h1_0000_0000 - {1'b0, d}) : d;
    if (m == 0) begin
      r   = 32'h0;
      lat = 1;
      return;
    end
    p = 31;
    while (!m[p]) p--;
    e    = 127 + p - FB;
    norm = m << (31 - p);
    r    = {s, 8'(e), norm[30:8]};
    lat  = 1 + (31 - p);
  endfunction

  function automatic logic cur_rdy();
    return sel ? rdy1 : rdy0;
  endfunction

  function automatic logic cur_ov();
    return sel ? ov1 : ov0;
  endfunction

  task automatic send(input logic [31:0] d);
    logic [31:0] r;
    int          l, n;
    @(negedge clk);
    data     = d;
    in_valid = 1'b1;
    n        = 0;
    while (!cur_rdy() && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: data 0x%08h never accepted", d);
    end else begin
      model(d, !sel, r, l);
      sbq.push_back('{res: r, lat: l, acc: cyc + 1});
      last_acc = cyc + 1;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || cur_ov()) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding", sbq.size());
    end
  endtask

  // Monitor: compares each presented result and its latency, and that a held
  // result does not change while backpressured.
  always @(negedge clk) begin
    sb_t e;
    if (!rst_n) begin
      seen = 1'b0;
    end else begin
      if (sel ? ov0 : ov1) check("idle_instance_out_valid", 32'(sel ? ov0 : ov1), 32'd0);
      if (cur_ov()) begin
        if (!seen) begin
          seen = 1'b1;
          held = sel ? res1 : res0;
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got 0x%08h with empty scoreboard", held);
          end else begin
            e = sbq.pop_front();
            check("result", held, e.res);
            check("latency", 32'(cyc - e.acc), 32'(e.lat));
          end
        end else begin
          check("held_result", sel ? res1 : res0, held);
        end
        if (out_ready) begin
          seen     = 1'b0;
          xfer_cyc = cyc + 1;
        end
      end
    end
  end

  initial begin
    logic [31:0] d;
    int n;

    #1;
    check("rst_in_ready_s", 32'(rdy0), 32'd1);
    check("rst_in_ready_u", 32'(rdy1), 32'd1);
    check("rst_out_valid", 32'({ov0, ov1}), 32'd0);
    check("rst_result", res0 | res1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rmode = 0;
    @(negedge clk);

    // Directed corners, signed instance; latency is checked by the monitor.
    send(32'h4000_0000);
    drain();
    send(32'h2000_0000);
    send(32'hC000_0000);
    send(32'h8000_0000);
    send(32'h0000_0000);
    send(32'h0000_0001);
    send(32'hFFFF_FFFF);
    send(32'h7FFF_FFFF);
    drain();

    // Unsigned instance: bit 31 is a value bit.
    sel = 1'b1;
    send(32'h7FFF_FFFF);
    send(32'h8000_0000);
    send(32'hFFFF_FFFF);
    send(32'h0000_0000);
    drain();

    // Randomised traffic with random downstream backpressure.
    rmode = 1;
    for (int i = 0; i < 40; i++) begin
      d = $urandom() >> $urandom_range(0, 31);
      send(d);
    end
    drain();
    sel = 1'b0;
    for (int i = 0; i < 120; i++) begin
      d = $urandom() >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) d = ~d;
      send(d);
    end
    drain();

    // Backpressure with the next operand waiting on in_valid.
    rmode     = 2;
    out_ready = 1'b0;
    send(32'h4000_0000);
    fork
      send(32'h2000_0000);
      begin
        n = 0;
        while (!ov0 && n < 100) begin
          @(negedge clk);
          n++;
        end
        for (int k = 0; k < 5; k++) begin
          check("bp_out_valid", 32'(ov0), 32'd1);
          check("bp_in_ready", 32'(rdy0), 32'd0);
          check("bp_result", res0, 32'h3F80_0000);
          @(negedge clk);
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    check("bp_second_accept", 32'(last_acc), 32'(xfer_cyc + 1));
    rmode = 0;
    drain();

    // Reset in the middle of normalisation.
    send(32'h0000_0100);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(rdy0), 32'd1);
    check("midrst_out_valid", 32'(ov0), 32'd0);
    check("midrst_result", res0, 32'h0);
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      check("postrst_out_valid", 32'(ov0), 32'd0);
      check("postrst_in_ready", 32'(rdy0), 32'd1);
    end
    send(32'h4000_0000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_packer
